// File: rtl/dither_pkg.sv
// Shared types and constants for the Floyd-Steinberg error diffuser.
// Optional build macro FS_ROUND_EN (used by fs_error_diffuser) selects
// round-half-up diffusion terms instead of floor.
package dither_pkg;

  // Diffusion neighbours in the order they are visited for each pixel.
  typedef enum logic [1:0] {
    NB_R  = 2'd0,
    NB_DL = 2'd1,
    NB_D  = 2'd2,
    NB_DR = 2'd3
  } neighbour_e;

  // Where the current pixel is in its fetch / quantise / diffuse sequence.
  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_FETCHED = 2'd1,
    PH_DIFFUSE = 2'd2
  } phase_e;

  localparam int NB_COUNT = 4;

  // Floyd-Steinberg weights, in sixteenths.
  localparam logic [3:0] W_R  = 4'd7;
  localparam logic [3:0] W_DL = 4'd3;
  localparam logic [3:0] W_D  = 4'd5;
  localparam logic [3:0] W_DR = 4'd1;

  localparam int WEIGHT_SHIFT = 4;
  localparam int PIX_MAX      = 255;

  function automatic logic [3:0] nb_weight(input neighbour_e nb);
    case (nb)
      NB_R:    return W_R;
      NB_DL:   return W_DL;
      NB_D:    return W_D;
      default: return W_DR;
    endcase
  endfunction

endpackage

// File: rtl/fs_neighbour_addr.sv
// Neighbour address and edge-validity decode for one diffusion target.
// Purely combinational; the image is row-major with power-of-2 dimensions.
module fs_neighbour_addr
  import dither_pkg::*;
#(
  parameter int IMAGEX           = 256,
  parameter int IMAGEY           = 256,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGEX * IMAGEY)
) (
  input  logic [IMAGE_ADDR_WIDTH-1:0] png_idx,
  input  neighbour_e                  nb,
  output logic [IMAGE_ADDR_WIDTH-1:0] nb_addr,
  output logic                        nb_valid
);

  localparam int AW  = IMAGE_ADDR_WIDTH;
  localparam int X_W = $clog2(IMAGEX);
  localparam int Y_W = AW - X_W;

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           at_left;
  logic           at_right;
  logic           at_bottom;

  assign x         = png_idx[X_W-1:0];
  assign y         = png_idx[AW-1:X_W];
  assign at_left   = (x == '0);
  assign at_right  = (x == X_W'(IMAGEX - 1));
  assign at_bottom = (y == Y_W'(IMAGEY - 1));

  // Offset the pixel index toward the selected neighbour and mask off-image targets.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    nb_addr  = png_idx;
    nb_valid = 1'b0;
    case (nb)
      NB_R: begin
        nb_addr  = png_idx + AW'(1);
        nb_valid = !at_right;
      end
      NB_DL: begin
        nb_addr  = png_idx + AW'(IMAGEX - 1);
        nb_valid = !at_bottom && !at_left;
      end
      NB_D: begin
        nb_addr  = png_idx + AW'(IMAGEX);
        nb_valid = !at_bottom;
      end
      default: begin
        nb_addr  = png_idx + AW'(IMAGEX + 1);
        nb_valid = !at_bottom && !at_right;
      end
    endcase
  end

endmodule

// File: rtl/fs_error_diffuser.sv
// Floyd-Steinberg datapath: quantises each pixel to 0/255, writes it back
// over SRAM port A, and diffuses the signed error into up to four
// neighbours by read (port B) / modify / write (port A).
// Build option: define FS_ROUND_EN for round-half-up diffusion terms;
// default build floors them.
module fs_error_diffuser
  import dither_pkg::*;
#(
  parameter int IMAGEX           = 256,
  parameter int IMAGEY           = 256,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGEX * IMAGEY),
  parameter int PIX_W            = 8,
  parameter int THRESH           = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        store_old_p,
  input  logic                        compare_and_store_n,
  input  logic [5:0]                  compute_fin,
  input  logic [IMAGE_ADDR_WIDTH-1:0] png_idx,
  output logic [IMAGE_ADDR_WIDTH-1:0] addr_a,
  output logic [PIX_W-1:0]            data_a,
  output logic                        wren_a,
  output logic [IMAGE_ADDR_WIDTH-1:0] addr_b,
  output logic                        rden_b,
  input  logic [PIX_W-1:0]            q_b,
  output logic [PIX_W:0]              err_out,
  output logic                        seq_err
);

  localparam int AW     = IMAGE_ADDR_WIDTH;
  localparam int PROD_W = PIX_W + 5;  // err (9b) * weight (<=7)
  localparam int SUM_W  = PIX_W + 3;  // pixel + term, headroom for clamping

  phase_e                  phase_q;
  phase_e                  phase_d;
  logic [PIX_W-1:0]        old_p_q;
  logic                    seq_err_q;
  logic                    load_old;

  logic [AW-1:0]           nb_addr [NB_COUNT];
  logic [NB_COUNT-1:0]     nb_valid;

  logic                    illegal;
  logic [PIX_W-1:0]        new_p;
  logic signed [PIX_W:0]   err;

  logic                    wr_slot;
  logic                    rd_slot;
  neighbour_e              wr_nb;
  neighbour_e              rd_nb;

  logic signed [PROD_W-1:0] err_ext;
  logic signed [PROD_W-1:0] w_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] term;
  logic signed [SUM_W-1:0]  sum;
  logic [PIX_W-1:0]         upd;

  function automatic logic [PIX_W-1:0] quantise(input logic [PIX_W-1:0] p);
    return (p >= PIX_W'(THRESH)) ? PIX_W'(PIX_MAX) : '0;
  endfunction

  for (genvar k = 0; k < NB_COUNT; k++) begin : g_nb
    fs_neighbour_addr #(
      .IMAGEX           (IMAGEX),
      .IMAGEY           (IMAGEY),
      .IMAGE_ADDR_WIDTH (IMAGE_ADDR_WIDTH)
    ) u_addr (
      .png_idx  (png_idx),
      .nb       (neighbour_e'(2'(k))),
      .nb_addr  (nb_addr[k]),
      .nb_valid (nb_valid[k])
    );
  end

  // More than one strobe in a cycle (including a non-one-hot phase) is a sequencing error.
  assign illegal = ($countones({store_old_p, compare_and_store_n, compute_fin}) > 1);

  assign new_p = quantise(q_b);

  // Error is a pure function of the latched pixel, so it follows old_p's register timing.
  assign err     = $signed({1'b0, old_p_q} - {1'b0, quantise(old_p_q)});
  assign err_out = err;
  assign seq_err = seq_err_q;

  // Decode which neighbour is written back (k-1) and which is read (k) this phase.
  always_comb begin
    wr_slot = 1'b0;
    rd_slot = 1'b0;
    wr_nb   = NB_R;
    rd_nb   = NB_R;
    for (int k = 0; k < NB_COUNT; k++) begin
      if (compute_fin[k]) begin
        rd_slot = 1'b1;
        rd_nb   = neighbour_e'(2'(k));
      end
      if (compute_fin[k+1]) begin
        wr_slot = 1'b1;
        wr_nb   = neighbour_e'(2'(k));
      end
    end
  end

  // Weighted error term added to the neighbour's read-back value, then clamped to pixel range.
  always_comb begin
    err_ext = PROD_W'(err);
    w_ext   = $signed(PROD_W'(nb_weight(wr_nb)));
    prod    = err_ext * w_ext;
`ifdef FS_ROUND_EN
    term    = (prod + PROD_W'(1 << (WEIGHT_SHIFT - 1))) >>> WEIGHT_SHIFT;
`else
    term    = prod >>> WEIGHT_SHIFT;
`endif
    sum     = SUM_W'(term) + $signed({3'b000, q_b});
    if (sum < 0) begin
      upd = '0;
    end else if (sum > SUM_W'(PIX_MAX)) begin
      upd = PIX_W'(PIX_MAX);
    end else begin
      upd = sum[PIX_W-1:0];
    end
  end

  // Phase sequencing and SRAM port control for the current strobe.
  always_comb begin
    phase_d  = phase_q;
    load_old = 1'b0;
    wren_a   = 1'b0;
    addr_a   = '0;
    data_a   = '0;
    rden_b   = 1'b0;
    addr_b   = '0;

    if (illegal) begin
      phase_d = PH_IDLE;
    end else begin
      if (store_old_p) begin
        rden_b  = 1'b1;
        addr_b  = png_idx;
        phase_d = PH_FETCHED;
      end
      if (compare_and_store_n && phase_q == PH_FETCHED) begin
        load_old = 1'b1;
        wren_a   = 1'b1;
        addr_a   = png_idx;
        data_a   = new_p;
        phase_d  = PH_DIFFUSE;
      end
      if (phase_q == PH_DIFFUSE) begin
        if (wr_slot && nb_valid[wr_nb]) begin
          wren_a = 1'b1;
          addr_a = nb_addr[wr_nb];
          data_a = upd;
        end
        if (rd_slot && nb_valid[rd_nb]) begin
          rden_b = 1'b1;
          addr_b = nb_addr[rd_nb];
        end
        if (compute_fin[5]) begin
          phase_d = PH_IDLE;
        end
      end
    end

    // A reset cycle drops whatever the strobes asked for.
    if (rst) begin
      load_old = 1'b0;
      wren_a   = 1'b0;
      addr_a   = '0;
      data_a   = '0;
      rden_b   = 1'b0;
      addr_b   = '0;
    end
  end

  // Phase, latched pixel and sticky sequencing flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      phase_q   <= PH_IDLE;
      old_p_q   <= '0;
      seq_err_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (load_old) begin
        old_p_q <= q_b;
      end
      if (illegal) begin
        seq_err_q <= 1'b1;
      end
    end
  end

endmodule
